// File: rtl/core_pkg.sv
// core_pkg: instruction field positions, phase encoding and error indices for the core instruction bus
package core_pkg;
  localparam int INST_W = 37;
  localparam int INST_LOAD = 0;
  localparam int INST_EXECUTE = 1;
  localparam int INST_L0_WR = 2;
  localparam int INST_L0_RD = 3;
  localparam int INST_IFIFO_RD = 4;
  localparam int INST_IFIFO_WR = 5;
  localparam int INST_OFIFO_RD = 6;
  localparam int A_XMEM_LSB = 7;
  localparam int A_XMEM_MSB = 17;
  localparam int INST_WEN_XMEM = 18;
  localparam int INST_CEN_XMEM = 19;
  localparam int A_PMEM_LSB = 20;
  localparam int A_PMEM_MSB = 30;
  localparam int INST_WEN_PMEM = 31;
  localparam int INST_CEN_PMEM = 32;
  localparam int INST_ACC = 33;
  localparam int INST_DATA_MODE = 34;
  localparam int INST_MODE = 35;
  localparam int INST_L0_RD_MODE = 36;
  localparam int ERR_LDEX = 0;
  localparam int ERR_L0 = 1;
  localparam int ERR_IFIFO = 2;
  localparam int ERR_GAP = 3;
  localparam int ERR_BURST = 4;
  localparam int ERR_W = 5;
  localparam logic [INST_W-1:0] INST_RST = (37'd1 << INST_CEN_PMEM) | (37'd1 << INST_WEN_PMEM) |
                                           (37'd1 << INST_CEN_XMEM) | (37'd1 << INST_WEN_XMEM);
  typedef enum logic [2:0] {PH_IDLE, PH_XWR, PH_PWR, PH_L0WR, PH_LOAD, PH_GAP, PH_EXEC} phase_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter; a clear that coincides with an increment restarts at 1
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);
  logic [WIDTH-1:0] value_d, value_q;
  always_comb value_d = clr ? WIDTH'(inc) : (inc && value_q < WIDTH'(MAX)) ? value_q + 1'b1 : value_q;
  always_ff @(posedge clk) value_q <= rst ? '0 : value_d;
  assign value = value_q;
endmodule

// File: rtl/core_inst_dec.sv
// core_inst_dec: registers the core instruction word, tracks the kij pass phase and flags protocol errors
module core_inst_dec import core_pkg::*; #(
  parameter int row = 8,
  parameter int col = 8,
  parameter int addr_w = 11,
  parameter int gap_min = 10,
  parameter int cnt_w = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] inst,
  output logic              l0_rd_mode_o,
  output logic              mode_o,
  output logic              data_mode_o,
  output logic              acc_o,
  output logic              cen_pmem_o,
  output logic              wen_pmem_o,
  output logic [addr_w-1:0] a_pmem_o,
  output logic              cen_xmem_o,
  output logic              wen_xmem_o,
  output logic [addr_w-1:0] a_xmem_o,
  output logic              ofifo_rd_o,
  output logic              ififo_wr_o,
  output logic              ififo_rd_o,
  output logic              l0_rd_o,
  output logic              l0_wr_o,
  output logic              execute_o,
  output logic              load_o,
  output logic [2:0]        phase,
  output logic [cnt_w-1:0]  load_cnt,
  output logic [cnt_w-1:0]  exec_cnt,
  output logic [ERR_W-1:0]  err
);
  logic [INST_W-1:0] inst_d, inst_q;
  phase_e phase_d, phase_q;
  logic [ERR_W-1:0] err_d, err_q;
  logic [cnt_w-1:0] gap_cnt;
  logic ld, ex, enter_load, enter_exec, leave_load;
  always_comb begin
    inst_d = inst;
    ld = inst_q[INST_LOAD];
    ex = inst_q[INST_EXECUTE];
    phase_d = ld ? PH_LOAD :
              ex ? PH_EXEC :
              inst_q[INST_L0_WR] ? PH_L0WR :
              !(inst_q[INST_CEN_PMEM] | inst_q[INST_WEN_PMEM]) ? PH_PWR :
              !(inst_q[INST_CEN_XMEM] | inst_q[INST_WEN_XMEM]) ? PH_XWR :
              (phase_q == PH_LOAD || phase_q == PH_GAP) ? PH_GAP : PH_IDLE;
    enter_load = ld && phase_q != PH_LOAD;
    enter_exec = phase_d == PH_EXEC && phase_q != PH_EXEC;
    leave_load = phase_q == PH_LOAD && phase_d != PH_LOAD;
    err_d = err_q;
    err_d[ERR_LDEX] = err_q[ERR_LDEX] | (ld & ex);
    err_d[ERR_L0] = err_q[ERR_L0] | (inst_q[INST_L0_RD] & inst_q[INST_L0_WR]);
    err_d[ERR_IFIFO] = err_q[ERR_IFIFO] | (inst_q[INST_IFIFO_RD] & inst_q[INST_IFIFO_WR]);
    // an execute straight out of LOAD has had no idle gap at all
    err_d[ERR_GAP] = err_q[ERR_GAP] |
                     (ex && (phase_q == PH_LOAD || (phase_q == PH_GAP && gap_cnt < cnt_w'(gap_min))));
    err_d[ERR_BURST] = err_q[ERR_BURST] | (leave_load && load_cnt != cnt_w'(row));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q <= INST_RST;
      phase_q <= PH_IDLE;
      err_q <= '0;
    end else begin
      inst_q <= inst_d;
      phase_q <= phase_d;
      err_q <= err_d;
    end
  end
  sat_counter #(.WIDTH(cnt_w), .MAX((1 << cnt_w) - 1)) u_load (
    .clk(clk), .rst(reset), .clr(enter_load), .inc(ld), .value(load_cnt)
  );
  sat_counter #(.WIDTH(cnt_w), .MAX((1 << cnt_w) - 1)) u_exec (
    .clk(clk), .rst(reset), .clr(enter_exec), .inc(ex && phase_d == PH_EXEC), .value(exec_cnt)
  );
  sat_counter #(.WIDTH(cnt_w), .MAX(gap_min)) u_gap (
    .clk(clk), .rst(reset), .clr(leave_load), .inc(phase_d == PH_GAP), .value(gap_cnt)
  );
  assign l0_rd_mode_o = inst_q[INST_L0_RD_MODE];
  assign mode_o = inst_q[INST_MODE];
  assign data_mode_o = inst_q[INST_DATA_MODE];
  assign acc_o = inst_q[INST_ACC];
  assign cen_pmem_o = inst_q[INST_CEN_PMEM];
  assign wen_pmem_o = inst_q[INST_WEN_PMEM];
  assign a_pmem_o = inst_q[A_PMEM_MSB:A_PMEM_LSB];
  assign cen_xmem_o = inst_q[INST_CEN_XMEM];
  assign wen_xmem_o = inst_q[INST_WEN_XMEM];
  assign a_xmem_o = inst_q[A_XMEM_MSB:A_XMEM_LSB];
  assign ofifo_rd_o = inst_q[INST_OFIFO_RD];
  assign ififo_wr_o = inst_q[INST_IFIFO_WR];
  assign ififo_rd_o = inst_q[INST_IFIFO_RD];
  assign l0_rd_o = inst_q[INST_L0_RD];
  assign l0_wr_o = inst_q[INST_L0_WR];
  assign execute_o = inst_q[INST_EXECUTE];
  assign load_o = inst_q[INST_LOAD];
  assign phase = phase_q;
  assign err = err_q;
endmodule

// File: tb/tb_core_inst_dec.sv
// tb_core_inst_dec: directed protocol scenarios plus randomized bursts against a behavioural model
module tb_core_inst_dec;
  localparam logic [36:0] IDLE_W = 37'h1800C0000;
  localparam logic [36:0] LD_W = IDLE_W | 37'h1;
  localparam logic [36:0] EX_W = IDLE_W | 37'h2;
  localparam logic [36:0] L0W_W = IDLE_W | 37'h4;
  localparam int P_IDLE = 0, P_XWR = 1, P_PWR = 2, P_L0WR = 3, P_LOAD = 4, P_GAP = 5, P_EXEC = 6;
  logic clk = 0;
  logic reset = 1;
  logic [36:0] inst;
  logic l0_rd_mode_o, mode_o, data_mode_o, acc_o, cen_pmem_o, wen_pmem_o, cen_xmem_o, wen_xmem_o;
  logic [10:0] a_pmem_o, a_xmem_o;
  logic ofifo_rd_o, ififo_wr_o, ififo_rd_o, l0_rd_o, l0_wr_o, execute_o, load_o;
  logic [2:0] phase;
  logic [7:0] load_cnt, exec_cnt;
  logic [4:0] err;
  logic [36:0] dut_word;
  int vectors = 0;
  int miscompares = 0;
  logic [36:0] m_reg;
  int m_phase, m_lcnt, m_ecnt, m_gap, m_err;
  int seq[$];
  core_inst_dec dut (
    .clk(clk), .reset(reset), .inst(inst),
    .l0_rd_mode_o(l0_rd_mode_o), .mode_o(mode_o), .data_mode_o(data_mode_o), .acc_o(acc_o),
    .cen_pmem_o(cen_pmem_o), .wen_pmem_o(wen_pmem_o), .a_pmem_o(a_pmem_o),
    .cen_xmem_o(cen_xmem_o), .wen_xmem_o(wen_xmem_o), .a_xmem_o(a_xmem_o),
    .ofifo_rd_o(ofifo_rd_o), .ififo_wr_o(ififo_wr_o), .ififo_rd_o(ififo_rd_o),
    .l0_rd_o(l0_rd_o), .l0_wr_o(l0_wr_o), .execute_o(execute_o), .load_o(load_o),
    .phase(phase), .load_cnt(load_cnt), .exec_cnt(exec_cnt), .err(err)
  );
  assign dut_word = {l0_rd_mode_o, mode_o, data_mode_o, acc_o, cen_pmem_o, wen_pmem_o, a_pmem_o,
                     cen_xmem_o, wen_xmem_o, a_xmem_o, ofifo_rd_o, ififo_wr_o, ififo_rd_o,
                     l0_rd_o, l0_wr_o, execute_o, load_o};
  always #5 clk = ~clk;
  // behavioural view of one clock edge: phase rules, burst counts and sticky errors
  task automatic model_edge(input logic [36:0] w, input logic rst_in);
    logic ld, ex;
    int np;
    if (rst_in) begin
      m_reg = IDLE_W; m_phase = P_IDLE; m_lcnt = 0; m_ecnt = 0; m_gap = 0; m_err = 0;
      return;
    end
    ld = m_reg[0];
    ex = m_reg[1];
    if (ld) np = P_LOAD;
    else if (ex) np = P_EXEC;
    else if (m_reg[2]) np = P_L0WR;
    else if (!m_reg[32] && !m_reg[31]) np = P_PWR;
    else if (!m_reg[19] && !m_reg[18]) np = P_XWR;
    else if (m_phase == P_LOAD || m_phase == P_GAP) np = P_GAP;
    else np = P_IDLE;
    if (ld && ex) m_err |= 1;
    if (m_reg[3] && m_reg[2]) m_err |= 2;
    if (m_reg[4] && m_reg[5]) m_err |= 4;
    if (ex && (m_phase == P_LOAD || (m_phase == P_GAP && m_gap < 10))) m_err |= 8;
    if (m_phase == P_LOAD && np != P_LOAD && m_lcnt != 8) m_err |= 16;
    if (np == P_LOAD && m_phase != P_LOAD) m_lcnt = 1;
    else if (ld && m_lcnt < 255) m_lcnt++;
    if (np == P_EXEC && m_phase != P_EXEC) m_ecnt = 1;
    else if (np == P_EXEC && m_ecnt < 255) m_ecnt++;
    if (m_phase == P_LOAD && np != P_LOAD) m_gap = (np == P_GAP) ? 1 : 0;
    else if (np == P_GAP && m_gap < 10) m_gap++;
    m_phase = np;
    m_reg = w;
  endtask
  task automatic step(input logic [36:0] w);
    model_edge(w, reset);
    inst = w;
    @(posedge clk);
    #1;
  endtask
  task automatic step_track(input logic [36:0] w);
    step(w);
    if (seq.size() == 0 || seq[$] != int'(phase)) seq.push_back(int'(phase));
  endtask
  task automatic do_reset();
    reset = 1;
    step(IDLE_W);
    step(IDLE_W);
    reset = 0;
  endtask
  task automatic test_reset();
    logic [36:0] ones;
    ones = '1;
    reset = 1;
    for (int i = 0; i < 10; i++) begin
      step(ones);
      vectors++;
      if (dut_word !== IDLE_W || phase !== 3'd0 || err !== 5'd0 || load_cnt !== 8'd0 || exec_cnt !== 8'd0) begin
        miscompares++;
        $display("FAIL reset_state cyc%0d: word=%h phase=%0d err=%b lc=%0d ec=%0d, want word=%h phase=0 err=0 lc=0 ec=0",
                 i, dut_word, phase, err, load_cnt, exec_cnt, IDLE_W);
      end
    end
    reset = 0;
    step(ones);
    vectors++;
    if (dut_word !== ones) begin
      miscompares++;
      $display("FAIL reset_release: word=%h want %h", dut_word, ones);
    end
    do_reset();
  endtask
  task automatic test_xmem_write();
    int xwr;
    xwr = 0;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      step((IDLE_W & ~(37'h3 << 18)) | (37'(i) << 7));
      vectors++;
      if (a_xmem_o !== 11'(i) || cen_xmem_o !== 1'b0 || wen_xmem_o !== 1'b0) begin
        miscompares++;
        $display("FAIL xmem_addr i=%0d: a=%0d cen=%b wen=%b want a=%0d cen=0 wen=0", i, a_xmem_o, cen_xmem_o, wen_xmem_o, i);
      end
      if (int'(phase) == P_XWR) xwr++;
    end
    step(IDLE_W);
    if (int'(phase) == P_XWR) xwr++;
    step(IDLE_W);
    vectors++;
    if (xwr != 64 || phase !== 3'(P_IDLE)) begin
      miscompares++;
      $display("FAIL xmem_phase: xwr_cycles=%0d phase=%0d want 64 and %0d", xwr, phase, P_IDLE);
    end
  endtask
  task automatic test_load_exec();
    int exp_seq[5];
    exp_seq = '{P_IDLE, P_L0WR, P_LOAD, P_GAP, P_EXEC};
    do_reset();
    seq.delete();
    seq.push_back(int'(phase));
    repeat (8) step_track(L0W_W);
    repeat (8) step_track(LD_W);
    repeat (10) step_track(IDLE_W);
    repeat (64) step_track(EX_W);
    step_track(IDLE_W);
    vectors++;
    if (load_cnt !== 8'd8 || exec_cnt !== 8'd64 || err !== 5'd0) begin
      miscompares++;
      $display("FAIL load_exec_counts: lc=%0d ec=%0d err=%b want 8 64 00000", load_cnt, exec_cnt, err);
    end
    vectors++;
    if (seq.size() != 5) begin
      miscompares++;
      $display("FAIL phase_seq_len: got %0d phases want 5", seq.size());
    end else
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (seq[i] != exp_seq[i]) begin
          miscompares++;
          $display("FAIL phase_seq[%0d]: got %0d want %0d", i, seq[i], exp_seq[i]);
        end
      end
  endtask
  task automatic test_short_load();
    do_reset();
    repeat (7) step(LD_W);
    repeat (3) step(IDLE_W);
    vectors++;
    if (err !== 5'b10000) begin
      miscompares++;
      $display("FAIL short_burst: err=%b want 10000", err);
    end
    repeat (8) step(LD_W);
    repeat (3) step(IDLE_W);
    vectors++;
    if (err !== 5'b10000 || load_cnt !== 8'd8) begin
      miscompares++;
      $display("FAIL burst_sticky: err=%b lc=%0d want 10000 8", err, load_cnt);
    end
  endtask
  task automatic test_gap_violation();
    do_reset();
    repeat (8) step(LD_W);
    repeat (3) step(IDLE_W);
    step(EX_W);
    repeat (2) step(IDLE_W);
    vectors++;
    if (err !== 5'b01000) begin
      miscompares++;
      $display("FAIL short_gap: err=%b want 01000", err);
    end
  endtask
  task automatic test_multi_err();
    do_reset();
    step(IDLE_W | 37'hF);
    step(IDLE_W);
    vectors++;
    if (err !== 5'b00011) begin
      miscompares++;
      $display("FAIL multi_err: err=%b want 00011", err);
    end
  endtask
  task automatic test_mid_reset();
    do_reset();
    repeat (4) step(LD_W);
    reset = 1;
    step(LD_W);
    reset = 0;
    vectors++;
    if (load_cnt !== 8'd0 || phase !== 3'(P_IDLE) || err !== 5'd0) begin
      miscompares++;
      $display("FAIL mid_reset: lc=%0d phase=%0d err=%b want 0 0 00000", load_cnt, phase, err);
    end
    repeat (8) step(LD_W);
    repeat (2) step(IDLE_W);
    vectors++;
    if (load_cnt !== 8'd8 || phase !== 3'(P_GAP) || err !== 5'd0) begin
      miscompares++;
      $display("FAIL fresh_burst: lc=%0d phase=%0d err=%b want 8 %0d 00000", load_cnt, phase, err, P_GAP);
    end
  endtask
  task automatic test_random();
    int kind, left;
    logic [63:0] r;
    logic [36:0] w;
    left = 0;
    kind = 0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (left == 0) begin
        kind = $urandom_range(0, 19);
        left = $urandom_range(1, 14);
      end
      left--;
      r = {$urandom(), $urandom()};
      w = r[36:0];
      if (kind != 19) begin
        w[6:0] = 7'd0;
        w[32] = 1'b1; w[31] = 1'b1; w[19] = 1'b1; w[18] = 1'b1;
        if (kind <= 6) w[0] = 1'b1;
        else if (kind <= 11) w[1] = 1'b1;
        else if (kind <= 13) w[2] = 1'b1;
        else if (kind == 14) {w[32], w[31]} = 2'b00;
        else if (kind == 15) {w[19], w[18]} = 2'b00;
        else if (kind == 16) w[6:3] = r[40:37];
      end
      reset = ($urandom_range(0, 199) == 0);
      step(w);
      vectors++;
      if (dut_word !== m_reg || phase !== 3'(m_phase) || load_cnt !== 8'(m_lcnt) ||
          exec_cnt !== 8'(m_ecnt) || err !== 5'(m_err)) begin
        miscompares++;
        $display("FAIL random c=%0d: word=%h ph=%0d lc=%0d ec=%0d err=%b want word=%h ph=%0d lc=%0d ec=%0d err=%b",
                 c, dut_word, phase, load_cnt, exec_cnt, err, m_reg, m_phase, m_lcnt, m_ecnt, 5'(m_err));
      end
    end
    reset = 0;
  endtask
  initial begin
    test_reset();
    test_xmem_write();
    test_load_exec();
    test_short_load();
    test_gap_violation();
    test_multi_err();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
